// File: rtl/stage_pool2x2.sv
// 2x2 spatial pooling of a raster token stream: floor average, or signed max when STAGE_POOL_MAX_EN is defined.
// Latency: a pooled token is valid the cycle after the 4th token of its window is accepted.
// Backpressure: in_ready = ~out_valid | out_ready; a stalled result holds and blocks further input.
module stage_pool2x2 #(
   parameter int DW    = 16,
   parameter int IMG_W = 14,
   parameter int IMG_H = 14
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic signed [DW-1:0] out_data,
   input  logic                 out_ready,
   output logic                 frame_done,
   output logic                 busy
);
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int HW = IMG_W / 2;
   localparam int IW = (HW > 1) ? $clog2(HW) : 1;
`ifdef STAGE_POOL_MAX_EN
   localparam int PW = DW;
   localparam int LW = DW;
`else
   localparam int PW = DW + 1;
   localparam int LW = DW + 2;
`endif
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   generate
      if (IMG_W % 2 != 0) begin : g_bad_w
         $error("stage_pool2x2: IMG_W must be even");
      end
      if (IMG_H % 2 != 0) begin : g_bad_h
         $error("stage_pool2x2: IMG_H must be even");
      end
   endgenerate

   typedef enum logic {ROW_EVEN, ROW_ODD} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]        col;
   logic [RW-1:0]        row;
   logic [IW-1:0]        lidx;
   logic signed [PW-1:0] pair_reg, pair_in, pair_val;
   logic signed [LW-1:0] lbuf [HW];
   logic signed [LW-1:0] lbuf_rd, lbuf_wr;
   logic signed [DW-1:0] result;
   logic accept, col_end, frame_end, load, lbuf_we, out_hs, out_last;

   assign in_ready  = ~out_valid | out_ready;
   assign accept    = in_valid & in_ready;
   assign col_end   = (col == COL_LAST);
   assign frame_end = col_end & (row == ROW_LAST);
   assign lidx      = IW'(col >> 1);
   assign lbuf_rd   = lbuf[lidx];
   assign out_hs    = out_valid & out_ready;

`ifdef STAGE_POOL_MAX_EN
   assign pair_in  = in_data;
   assign pair_val = (in_data > pair_reg) ? in_data : pair_reg;
   assign lbuf_wr  = pair_val;
   assign result   = (lbuf_rd > pair_val) ? lbuf_rd : pair_val;
`else
   logic signed [LW-1:0] total;
   assign pair_in  = {in_data[DW-1], in_data};
   assign pair_val = pair_reg + pair_in;
   assign lbuf_wr  = {pair_val[PW-1], pair_val};
   assign total    = lbuf_rd + lbuf_wr;
   // Floor division by four; the mean of four DW-bit values always fits in DW.
   assign result   = DW'(total >>> 2);
`endif

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      lbuf_we   = 1'b0;
      case (state)
         ROW_EVEN: begin
            lbuf_we = accept & col[0];
            if (accept && col_end) state_nxt = ROW_ODD;
         end
         ROW_ODD: begin
            load = accept & col[0];
            if (accept && col_end) state_nxt = ROW_EVEN;
         end
         default: state_nxt = ROW_EVEN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         state      <= ROW_EVEN;
         col        <= '0;
         row        <= '0;
         pair_reg   <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         frame_done <= out_hs & out_last;
         // A new frame starting on the closing handshake keeps busy asserted.
         busy       <= (accept & (col == '0) & (row == '0)) | (busy & ~(out_hs & out_last));
         if (accept) begin
            if (!col[0]) pair_reg <= pair_in;
            if (col_end) begin
               col <= '0;
               row <= frame_end ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= result;
            out_last  <= frame_end;
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

   // Line buffer is never cleared: every entry is rewritten in the even row before it is read.
   always_ff @(posedge clk) begin
      if (lbuf_we) lbuf[lidx] <= lbuf_wr;
   end
endmodule

// File: tb/tb_stage_pool2x2.sv
// Directed bench for stage_pool2x2 on a 4x4 grid; expected values follow the build (average or max).
module tb_stage_pool2x2;
   logic               clk = 1'b0;
   logic               rstn;
   logic               in_valid;
   logic signed [15:0] in_data;
   logic               in_ready;
   logic               out_valid;
   logic signed [15:0] out_data;
   logic               out_ready;
   logic               frame_done;
   logic               busy;

   int checks = 0;
   int errors = 0;
   int got[$];
   int fd_cnt = 0;

`ifdef STAGE_POOL_MAX_EN
   localparam int R0 = 5, R1 = 7, R2 = 13, R3 = 15;
   localparam int M0 = 0, M1 = -2;
`else
   localparam int R0 = 2, R1 = 4, R2 = 10, R3 = 12;
   localparam int M0 = -1, M1 = -6;
`endif

   int mix [16] = '{-1, -1, -8, -2,
                    -1,  0, -5, -7,
                    32767, 32767, -32768, -32768,
                    32767, 32767, -32768, -32768};

   stage_pool2x2 #(.DW(16), .IMG_W(4), .IMG_H(4)) dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   // Outputs are sampled mid-cycle; a valid+ready seen here completes on the next rising edge.
   always @(negedge clk) begin
      if (out_valid && out_ready) got.push_back(int'(out_data));
      if (frame_done) fd_cnt++;
   end

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic send(input int d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = 16'(d);
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_outs(input string tag, input int a, input int b, input int c, input int d);
      int e[4];
      e = '{a, b, c, d};
      chk({tag, "_count"}, int'(got.size() >= 4), 1);
      if (got.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_%0d", tag, i), got[0], e[i]);
            void'(got.pop_front());
         end
      end
   endtask

   initial begin
      rstn = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      idle(3);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rstn = 1'b0;
      idle(2);

      // Ramp frame with frame_done timing.
      fd_cnt = 0;
      send(0);
      @(negedge clk);
      chk("busy_first", busy, 1);
      @(posedge clk); #1;
      for (int i = 1; i < 16; i++) send(i);
      @(negedge clk);
      chk("last_vld", out_valid, 1);
      chk("last_fd_early", frame_done, 0);
      @(negedge clk);
      chk("fd_pulse", frame_done, 1);
      chk("fd_busy_clr", busy, 0);
      chk("fd_vld_clr", out_valid, 0);
      @(negedge clk);
      chk("fd_one_cycle", frame_done, 0);
      @(posedge clk); #1;
      chk_outs("ramp", R0, R1, R2, R3);
      chk("ramp_fd_cnt", fd_cnt, 1);

      // Constant negative frame.
      for (int i = 0; i < 16; i++) send(-3);
      idle(4);
      chk_outs("neg3", -3, -3, -3, -3);

      // Rounding, sign and full-scale windows.
      for (int i = 0; i < 16; i++) send(mix[i]);
      idle(4);
      chk_outs("mix", M0, M1, 32767, -32768);

      // Downstream stall on the first result.
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(i);
      in_valid = 1'b1;
      in_data  = 16'sd6;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("hold_vld_%0d", k), out_valid, 1);
         chk($sformatf("hold_dat_%0d", k), out_data, R0);
         chk($sformatf("hold_rdy_%0d", k), in_ready, 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 6; i < 16; i++) send(i);
      idle(4);
      chk_outs("stall", R0, R1, R2, R3);

      // Back-to-back frames; the second frame starts on the first frame's closing handshake.
      fd_cnt = 0;
      for (int i = 0; i < 16; i++) send(i);
      send(16);
      @(negedge clk);
      chk("b2b_fd", frame_done, 1);
      chk("b2b_busy", busy, 1);
      @(posedge clk); #1;
      for (int i = 17; i < 32; i++) send(i);
      idle(4);
      chk("b2b_fd_cnt", fd_cnt, 2);
      chk_outs("b2b_f0", R0, R1, R2, R3);
      chk_outs("b2b_f1", R0 + 16, R1 + 16, R2 + 16, R3 + 16);

      // Reset mid-frame with a pending result.
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(i);
      @(negedge clk);
      chk("pre_rst_vld", out_valid, 1);
      @(posedge clk); #1;
      rstn = 1'b1;
      idle(1);
      rstn = 1'b0;
      @(negedge clk);
      chk("mid_rst_vld", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) send(i);
      idle(4);
      chk_outs("post_rst", R0, R1, R2, R3);
      chk("leftover", got.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
